ccg_vector_tester: RTL and testbench

CCG_VECTOR_TESTER -- requirements
Module: ccg_vector_tester

---
 rtl/ccg_vector_tester.sv | 116 +++++++++++
 tb/tb_ccg_vector_tester.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/ccg_vector_tester.sv
// Exhaustive 3-input vector tester: sweeps x[2:0] through 0..7, captures
// {f2,f1} per vector into a response map and a 16-bit MISR signature.
module ccg_vector_tester #(
  parameter int unsigned  SETTLE    = 1,
  parameter logic [15:0]  EXP_RESP  = 16'h0000,
  parameter logic [15:0]  MISR_SEED = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        x0,
  output logic        x1,
  output logic        x2,
  input  logic        f1,
  input  logic        f2,
  output logic        busy,
  output logic        done,
  output logic [15:0] resp,
  output logic [15:0] sig,
  output logic        pass
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_SAMPLE,
    S_DONE
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t      state_q, state_d;
  logic [2:0]  vec_q, vec_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] resp_q, resp_d;
  logic [15:0] sig_q, sig_d;
  logic        pass_q, pass_d;
  logic        fb;

  assign fb = sig_q[15] ^ sig_q[13] ^ sig_q[12] ^ sig_q[10];

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    resp_d  = resp_q;
    sig_d   = sig_q;
    pass_d  = pass_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_DRIVE;
          vec_d   = 3'd0;
          cnt_d   = 4'd0;
          resp_d  = 16'h0000;
          sig_d   = MISR_SEED;
          pass_d  = 1'b0;
        end
      end
      S_DRIVE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = S_SAMPLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_SAMPLE: begin
        resp_d[{vec_q, 1'b0} +: 2] = {f2, f1};
        sig_d = {sig_q[14:0], fb} ^ {14'b0, f2, f1};
        if (vec_q == 3'd7) begin
          state_d = S_DONE;
          // pass is ready alongside the done pulse
          pass_d  = (resp_d == EXP_RESP);
        end else begin
          state_d = S_DRIVE;
          vec_d   = vec_q + 3'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      vec_q   <= 3'd0;
      cnt_q   <= 4'd0;
      resp_q  <= 16'h0000;
      sig_q   <= MISR_SEED;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      resp_q  <= resp_d;
      sig_q   <= sig_d;
      pass_q  <= pass_d;
    end
  end

  assign x0   = vec_q[0];
  assign x1   = vec_q[1];
  assign x2   = vec_q[2];
  assign busy = (state_q == S_DRIVE) || (state_q == S_SAMPLE);
  assign done = (state_q == S_DONE);
  assign resp = resp_q;
  assign sig  = sig_q;
  assign pass = pass_q;

endmodule

// File: tb/tb_ccg_vector_tester.sv
// Directed bench for ccg_vector_tester: three instances covering
// tied responses, a modelled circuit, SETTLE=3, ignored starts, reset.
module tb_ccg_vector_tester;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_r [3];
  logic        busy_w  [3];
  logic        done_w  [3];
  logic        pass_w  [3];
  logic [2:0]  x_w     [3];
  logic [15:0] resp_w  [3];
  logic [15:0] sig_w   [3];
  logic [1:0]  tie;
  logic        force2;
  logic        m_f1, m_f2;
  int          n_chk = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  assign m_f1 = (x_w[1][0] ^ x_w[1][1]) & ~x_w[1][2]
              & ~(force2 && x_w[1] == 3'd2);
  assign m_f2 = ~x_w[1][1] & ~x_w[1][2];

  ccg_vector_tester #(.SETTLE(1), .EXP_RESP(16'h0000)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start_r[0]),
    .x0(x_w[0][0]), .x1(x_w[0][1]), .x2(x_w[0][2]),
    .f1(tie[0]), .f2(tie[1]),
    .busy(busy_w[0]), .done(done_w[0]),
    .resp(resp_w[0]), .sig(sig_w[0]), .pass(pass_w[0])
  );

  ccg_vector_tester #(.SETTLE(1), .EXP_RESP(16'h001E)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start_r[1]),
    .x0(x_w[1][0]), .x1(x_w[1][1]), .x2(x_w[1][2]),
    .f1(m_f1), .f2(m_f2),
    .busy(busy_w[1]), .done(done_w[1]),
    .resp(resp_w[1]), .sig(sig_w[1]), .pass(pass_w[1])
  );

  ccg_vector_tester #(.SETTLE(3), .EXP_RESP(16'h0000)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start_r[2]),
    .x0(x_w[2][0]), .x1(x_w[2][1]), .x2(x_w[2][2]),
    .f1(tie[0]), .f2(tie[1]),
    .busy(busy_w[2]), .done(done_w[2]),
    .resp(resp_w[2]), .sig(sig_w[2]), .pass(pass_w[2])
  );

  typedef struct {
    string       nm;
    int          id;
    int          settle;
    logic [1:0]  tie;
    logic        force2;
    int          poke;
    logic [15:0] er;
    logic        ep;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [15:0] misr_model(input logic [15:0] r);
    logic [15:0] s;
    logic        f;
    s = 16'hFFFF;
    for (int v = 0; v < 8; v++) begin
      f = s[15] ^ s[13] ^ s[12] ^ s[10];
      s = {s[14:0], f} ^ {14'b0, r[2*v+1], r[2*v]};
    end
    return s;
  endfunction

  task automatic run(input vec_t v);
    int          last;
    logic [15:0] es;
    last = 8 * (v.settle + 1);
    es = misr_model(v.er);
    tie = v.tie;
    force2 = v.force2;
    @(negedge clk);
    start_r[v.id] = 1'b1;
    @(posedge clk);
    for (int k = 0; k <= last + 3; k++) begin
      @(negedge clk);
      start_r[v.id] = (k == v.poke);
      chk({v.nm, " busy"}, 32'(busy_w[v.id]), 32'(k < last));
      chk({v.nm, " done"}, 32'(done_w[v.id]), 32'(k == last));
      chk({v.nm, " x"}, 32'(x_w[v.id]),
          (k < last) ? 32'(k / (v.settle + 1)) : 32'd7);
      if (k < last) chk({v.nm, " pass_run"}, 32'(pass_w[v.id]), 32'd0);
      if (k == last) begin
        chk({v.nm, " resp"}, 32'(resp_w[v.id]), 32'(v.er));
        chk({v.nm, " sig"}, 32'(sig_w[v.id]), 32'(es));
        chk({v.nm, " pass"}, 32'(pass_w[v.id]), 32'(v.ep));
      end
    end
    start_r[v.id] = 1'b0;
    chk({v.nm, " resp_hold"}, 32'(resp_w[v.id]), 32'(v.er));
    chk({v.nm, " sig_hold"}, 32'(sig_w[v.id]), 32'(es));
    chk({v.nm, " pass_hold"}, 32'(pass_w[v.id]), 32'(v.ep));
  endtask

  task automatic chk_reset(input string nm, input int id);
    chk({nm, " ctl"}, {28'd0, busy_w[id], done_w[id], pass_w[id],
        1'b0}, 32'd0);
    chk({nm, " x"}, 32'(x_w[id]), 32'd0);
    chk({nm, " resp"}, 32'(resp_w[id]), 32'd0);
    chk({nm, " sig"}, 32'(sig_w[id]), 32'hFFFF);
  endtask

  vec_t tbl [8];

  initial begin
    tbl[0] = '{"zeros",   0, 1, 2'b00, 1'b0, -1, 16'h0000, 1'b1};
    tbl[1] = '{"ones",    0, 1, 2'b11, 1'b0, -1, 16'hFFFF, 1'b0};
    tbl[2] = '{"model",   1, 1, 2'b00, 1'b0, -1, 16'h001E, 1'b1};
    tbl[3] = '{"forced",  1, 1, 2'b00, 1'b1, -1, 16'h000E, 1'b0};
    tbl[4] = '{"s3zero",  2, 3, 2'b00, 1'b0, -1, 16'h0000, 1'b1};
    tbl[5] = '{"pokebsy", 0, 1, 2'b00, 1'b0,  4, 16'h0000, 1'b1};
    tbl[6] = '{"pokedone",0, 1, 2'b01, 1'b0, 16, 16'h5555, 1'b0};
    tbl[7] = '{"s3ones",  2, 3, 2'b11, 1'b0, -1, 16'hFFFF, 1'b0};

    for (int i = 0; i < 3; i++) start_r[i] = 1'b0;
    tie = 2'b00;
    force2 = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) chk_reset("rst", i);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run(tbl[i]);

    // abandon a run with reset at N+6
    tie = 2'b00;
    @(negedge clk);
    start_r[0] = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      start_r[0] = 1'b0;
      chk("midrst busy", 32'(busy_w[0]), 32'd1);
      if (k == 5) rst_n = 1'b0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    chk_reset("midrst", 0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("midrst nodone", 32'(done_w[0]), 32'd0);
    end
    run(tbl[0]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
